// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and stage names for pipe_stage_chain.
package pipe_pkg;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int PERF_W = 32;
    typedef enum logic [1:0] {
        IF_ID  = 2'd0,
        ID_EX  = 2'd1,
        EX_MEM = 2'd2,
        MEM_WB = 2'd3
    } stage_e;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one stage's valid+data register; flush beats capture, empty slots hold NOP_WORD.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP = WIDTH'(pipe_pkg::NOP_WORD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cap,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
            r_data  <= NOP;
        end else if (i_cap) begin
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : NOP;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: pipeline register chain with stall back-pressure, flush and bubble collapsing.
// Define PIPE_PERF_CNT_EN to build the saturating performance counters; otherwise they read 0.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGES = 4,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(pipe_pkg::NOP_WORD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall_req,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    out_fire,
    output logic [PERF_W-1:0]       perf_stall_cycles,
    output logic [PERF_W-1:0]       perf_bubble_cycles,
    output logic [PERF_W-1:0]       perf_retired
);
    logic [STAGES-1:0]       w_held;
    logic [STAGES-1:0]       w_cap;
    logic [STAGES-1:0]       w_leave;
    logic [STAGES-1:0]       w_in_valid;
    logic [STAGES*WIDTH-1:0] w_in_data;
    logic                    w_down_cap;

    // Walk from the last stage back so each stage sees whether its successor can take its item.
    always_comb begin
        w_held     = '0;
        w_cap      = '0;
        w_leave    = '0;
        w_down_cap = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_held[k]  = stall_req[k] | ~w_down_cap;
            w_cap[k]   = ~stage_valid[k] | ~w_held[k];
            w_leave[k] = stage_valid[k] & ~w_held[k];
            w_down_cap = w_cap[k];
        end
    end

    assign w_in_valid = {w_leave[STAGES-2:0], in_valid};
    assign w_in_data  = {stage_data[(STAGES-1)*WIDTH-1:0], in_data};
    assign in_ready   = w_cap[0];
    assign out_fire   = w_leave[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        pipe_slot #(.WIDTH(WIDTH), .NOP(NOP_WORD)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_cap  (w_cap[g]),
            .i_flush(flush[g]),
            .i_valid(w_in_valid[g]),
            .i_data (w_in_data[g*WIDTH +: WIDTH]),
            .o_valid(stage_valid[g]),
            .o_data (stage_data[g*WIDTH +: WIDTH])
        );
    end

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_bubble_cnt;
    logic [PERF_W-1:0] r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt   <= '0;
            r_bubble_cnt  <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!stage_valid[STAGES-1] && !(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (out_fire && !(&r_retired_cnt)) r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

    assign perf_stall_cycles  = r_stall_cnt;
    assign perf_bubble_cycles = r_bubble_cnt;
    assign perf_retired       = r_retired_cnt;
`else
    assign perf_stall_cycles  = '0;
    assign perf_bubble_cycles = '0;
    assign perf_retired       = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed self-checking bench for pipe_stage_chain (default 4x32 configuration).
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int W = 32;
    localparam int S = 4;
    localparam logic [W-1:0] NOP = 32'h0000_0013;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [S-1:0]   stall_req;
    logic [S-1:0]   flush;
    logic [S-1:0]   stage_valid;
    logic [S*W-1:0] stage_data;
    logic           out_fire;
    logic [31:0]    perf_stall_cycles;
    logic [31:0]    perf_bubble_cycles;
    logic [31:0]    perf_retired;

    int errors = 0;
    int checks = 0;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .stall_req         (stall_req),
        .flush             (flush),
        .stage_valid       (stage_valid),
        .stage_data        (stage_data),
        .out_fire          (out_fire),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubble_cycles(perf_bubble_cycles),
        .perf_retired      (perf_retired)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] sd(input int k);
        return stage_data[k*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        stall_req = '0;
        flush = '0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", stage_valid); end
        checks++; if (stage_data !== {S{NOP}}) begin errors++; $display("FAIL reset_data got %h want %h", stage_data, {S{NOP}}); end
        checks++; if (in_ready !== 1'b1 || out_fire !== 1'b0) begin errors++; $display("FAIL reset_hs in_ready=%b out_fire=%b want 1 0", in_ready, out_fire); end
        checks++; if (perf_retired !== 0 || perf_stall_cycles !== 0 || perf_bubble_cycles !== 0) begin errors++; $display("FAIL reset_perf got %0d %0d %0d want 0 0 0", perf_stall_cycles, perf_bubble_cycles, perf_retired); end
    endtask

    task automatic test_flow();
        logic [31:0] exp_ret;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data = i;
            step();
            if (i == 4) begin
                checks++; if (sd(3) !== 32'd1 || sd(0) !== 32'd4) begin errors++; $display("FAIL flow_latency s3=%h s0=%h want 1 4", sd(3), sd(0)); end
            end
            if (i >= 4) begin
                checks++; if (out_fire !== 1'b1) begin errors++; $display("FAIL flow_fire%0d got %b want 1", i, out_fire); end
            end
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            checks++; if (out_fire !== 1'b1 || sd(3) !== 32'(3 + j)) begin errors++; $display("FAIL flow_drain%0d fire=%b s3=%h want 1 %h", j, out_fire, sd(3), 3 + j); end
        end
        step();
        checks++; if (out_fire !== 1'b0 || stage_valid !== 4'b0000) begin errors++; $display("FAIL flow_empty fire=%b valid=%b want 0 0000", out_fire, stage_valid); end
`ifdef PIPE_PERF_CNT_EN
        exp_ret = 32'd5;
`else
        exp_ret = 32'd0;
`endif
        checks++; if (perf_retired !== exp_ret) begin errors++; $display("FAIL flow_retired got %0d want %0d", perf_retired, exp_ret); end
    endtask

    task automatic test_stall_full();
        logic [31:0] exp_st;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 32'h10 + i;
            step();
        end
        stall_req = 4'b1000;
        in_data = 32'h99;
        #1;
        checks++; if (in_ready !== 1'b0 || out_fire !== 1'b0) begin errors++; $display("FAIL stall_hs in_ready=%b out_fire=%b want 0 0", in_ready, out_fire); end
        for (int c = 0; c < 3; c++) step();
        checks++; if (stage_valid !== 4'b1111 || sd(0) !== 32'h13 || sd(1) !== 32'h12 || sd(2) !== 32'h11 || sd(3) !== 32'h10) begin errors++; $display("FAIL stall_hold valid=%b data=%h want 1111 00000010000000110000001200000013", stage_valid, stage_data); end
`ifdef PIPE_PERF_CNT_EN
        exp_st = 32'd3;
`else
        exp_st = 32'd0;
`endif
        checks++; if (perf_stall_cycles !== exp_st) begin errors++; $display("FAIL stall_perf got %0d want %0d", perf_stall_cycles, exp_st); end
        stall_req = '0;
        in_valid = 1'b0;
    endtask

    task automatic test_bubble();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 32'hB; step();
        in_valid = 1'b0; step();
        checks++; if (stage_valid !== 4'b1010) begin errors++; $display("FAIL bubble_setup got %b want 1010", stage_valid); end
        stall_req = 4'b1000;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready0 got %b want 1", in_ready); end
        step();
        checks++; if (stage_valid !== 4'b1100 || sd(2) !== 32'hB || sd(1) !== NOP || sd(3) !== 32'hA) begin errors++; $display("FAIL bubble_collapse valid=%b s3=%h s2=%h s1=%h want 1100 a b 13", stage_valid, sd(3), sd(2), sd(1)); end
        in_valid = 1'b1; in_data = 32'hC; step();
        in_data = 32'hD; step();
        checks++; if (stage_valid !== 4'b1111 || in_ready !== 1'b0 || sd(0) !== 32'hD || sd(1) !== 32'hC) begin errors++; $display("FAIL bubble_full valid=%b in_ready=%b s1=%h s0=%h want 1111 0 c d", stage_valid, in_ready, sd(1), sd(0)); end
        stall_req = '0;
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = i;
            step();
        end
        flush = 4'b0011;
        in_data = 32'd5;
        step();
        checks++; if (stage_valid !== 4'b1100 || sd(0) !== NOP || sd(1) !== NOP || sd(2) !== 32'd3 || sd(3) !== 32'd2) begin errors++; $display("FAIL flush_low valid=%b data=%h want 1100 00000002000000030000001300000013", stage_valid, stage_data); end
        flush = '0;
        in_valid = 1'b0;
        step();
        checks++; if (stage_valid !== 4'b1000 || sd(3) !== 32'd3) begin errors++; $display("FAIL flush_drain valid=%b s3=%h want 1000 3", stage_valid, sd(3)); end
        step();
        checks++; if (stage_valid !== 4'b0000 || out_fire !== 1'b0) begin errors++; $display("FAIL flush_gone valid=%b fire=%b want 0000 0", stage_valid, out_fire); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        for (int i = 7; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data = i;
            step();
        end
        in_valid = 1'b0;
        flush = 4'b0100;
        stall_req = 4'b0100;
        step();
        checks++; if (stage_valid !== 4'b0011 || sd(2) !== NOP || sd(1) !== 32'd8 || sd(0) !== 32'd9) begin errors++; $display("FAIL fs_empty valid=%b s2=%h s1=%h s0=%h want 0011 13 8 9", stage_valid, sd(2), sd(1), sd(0)); end
        flush = '0;
        stall_req = '0;
        step();
        checks++; if (stage_valid !== 4'b0110 || sd(2) !== 32'd8 || sd(1) !== 32'd9) begin errors++; $display("FAIL fs_move valid=%b s2=%h s1=%h want 0110 8 9", stage_valid, sd(2), sd(1)); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 32'h40 + i;
            step();
        end
        stall_req = 4'b1000;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (stage_valid !== 4'b0000 || stage_data !== {S{NOP}}) begin errors++; $display("FAIL rstmid_state valid=%b data=%h want 0000 nop", stage_valid, stage_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        checks++; if (perf_stall_cycles !== 0 || perf_bubble_cycles !== 0 || perf_retired !== 0) begin errors++; $display("FAIL rstmid_perf got %0d %0d %0d want 0 0 0", perf_stall_cycles, perf_bubble_cycles, perf_retired); end
        in_valid = 1'b0;
        stall_req = '0;
    endtask

    initial begin
        test_reset();
        test_flow();
        test_stall_full();
        test_bubble();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
